// File: rtl/add_round_key_param.sv
// AddRoundKey over a dual-port state RAM and four per-row key ports, one column every 4 cycles.
// Define ARK_ROUND_CHECK_EN to reject round indices above NR_MAX (reported on ap_err).
module add_round_key_param #(
    parameter int DATA_W     = 32,
    parameter int KEY_W      = 8,
    parameter int NB         = 4,
    parameter int SA_W       = 5,
    parameter int KA_W       = 9,
    parameter int KEY_STRIDE = 120,
    parameter int N_W        = 6,
    parameter int NR_MAX     = 14
) (
    input  logic              ap_clk,
    input  logic              ap_rst,
    input  logic              ap_start,
    output logic              ap_done,
    output logic              ap_idle,
    output logic              ap_ready,
    output logic              ap_err,
    input  logic [N_W-1:0]    n,
    output logic [SA_W-1:0]   statemt_address0,
    output logic              statemt_ce0,
    output logic              statemt_we0,
    output logic [DATA_W-1:0] statemt_d0,
    input  logic [DATA_W-1:0] statemt_q0,
    output logic [SA_W-1:0]   statemt_address1,
    output logic              statemt_ce1,
    output logic              statemt_we1,
    output logic [DATA_W-1:0] statemt_d1,
    input  logic [DATA_W-1:0] statemt_q1,
    output logic [KA_W-1:0]   key_address0,
    output logic              key_ce0,
    input  logic [KEY_W-1:0]  key_q0,
    output logic [KA_W-1:0]   key_address1,
    output logic              key_ce1,
    input  logic [KEY_W-1:0]  key_q1,
    output logic [KA_W-1:0]   key_address2,
    output logic              key_ce2,
    input  logic [KEY_W-1:0]  key_q2,
    output logic [KA_W-1:0]   key_address3,
    output logic              key_ce3,
    input  logic [KEY_W-1:0]  key_q3
);

    // Column counter must reach NB itself to signal completion.
    localparam int J_W = $clog2(NB + 1);

    typedef enum logic [4:0] {
        IDLE = 5'b00001,
        CHK  = 5'b00010,
        RD   = 5'b00100,
        WA   = 5'b01000,
        WB   = 5'b10000
    } state_t;

    localparam logic [KA_W-1:0] ROW1_OFF = KA_W'(KEY_STRIDE);
    localparam logic [KA_W-1:0] ROW2_OFF = KA_W'(2 * KEY_STRIDE);
    localparam logic [KA_W-1:0] ROW3_OFF = KA_W'(3 * KEY_STRIDE);
    localparam logic [J_W-1:0]  J_END    = J_W'(NB);

    state_t            state_q, state_d;
    logic [J_W-1:0]    j_q, j_d;
    logic [KA_W-1:0]   base_q, base_d;
    logic [DATA_W-1:0] cap0_q, cap0_d, cap1_q, cap1_d;
    logic [DATA_W-1:0] x2_q, x2_d, x3_q, x3_d;
    logic              err_q, err_d;
    logic              col_done;
    logic              bad_round;
    logic [SA_W-1:0]   col_base;
    logic [KA_W-1:0]   key_col;

    assign col_done = (j_q == J_END);
    assign col_base = SA_W'({j_q, 2'b00});
    assign key_col  = base_q + KA_W'(j_q);

`ifdef ARK_ROUND_CHECK_EN
    assign bad_round = (32'(n) > 32'(NR_MAX));
`else
    assign bad_round = 1'b0;
`endif

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q <= IDLE;
            j_q     <= '0;
            base_q  <= '0;
            cap0_q  <= '0;
            cap1_q  <= '0;
            x2_q    <= '0;
            x3_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            j_q     <= j_d;
            base_q  <= base_d;
            cap0_q  <= cap0_d;
            cap1_q  <= cap1_d;
            x2_q    <= x2_d;
            x3_q    <= x3_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        j_d     = j_q;
        base_d  = base_q;
        cap0_d  = cap0_q;
        cap1_d  = cap1_q;
        x2_d    = x2_q;
        x3_d    = x3_q;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (ap_start) begin
                    state_d = CHK;
                    base_d  = KA_W'(32'(n) * 32'(NB));
                    // A rejected round skips straight to the completion check.
                    j_d     = bad_round ? J_END : '0;
                    err_d   = bad_round;
                end
            end
            CHK: state_d = col_done ? IDLE : RD;
            RD: begin
                state_d = WA;
                cap0_d  = statemt_q0;
                cap1_d  = statemt_q1;
            end
            WA: begin
                state_d = WB;
                x2_d    = statemt_q0 ^ DATA_W'(key_q2);
                x3_d    = statemt_q1 ^ DATA_W'(key_q3);
            end
            WB: begin
                state_d = CHK;
                j_d     = j_q + J_W'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        statemt_address0 = '0;
        statemt_address1 = '0;
        statemt_ce0      = 1'b0;
        statemt_ce1      = 1'b0;
        statemt_we0      = 1'b0;
        statemt_we1      = 1'b0;
        statemt_d0       = '0;
        statemt_d1       = '0;
        key_address0     = '0;
        key_address1     = '0;
        key_address2     = '0;
        key_address3     = '0;
        key_ce0          = 1'b0;
        key_ce1          = 1'b0;
        key_ce2          = 1'b0;
        key_ce3          = 1'b0;
        unique case (state_q)
            CHK: begin
                if (!col_done) begin
                    statemt_address0 = col_base;
                    statemt_address1 = col_base | SA_W'(1);
                    statemt_ce0      = 1'b1;
                    statemt_ce1      = 1'b1;
                end
            end
            RD: begin
                statemt_address0 = col_base | SA_W'(2);
                statemt_address1 = col_base | SA_W'(3);
                statemt_ce0      = 1'b1;
                statemt_ce1      = 1'b1;
                key_address0     = key_col;
                key_address1     = key_col + ROW1_OFF;
                key_address2     = key_col + ROW2_OFF;
                key_address3     = key_col + ROW3_OFF;
                key_ce0          = 1'b1;
                key_ce1          = 1'b1;
                key_ce2          = 1'b1;
                key_ce3          = 1'b1;
            end
            WA: begin
                statemt_address0 = col_base;
                statemt_address1 = col_base | SA_W'(1);
                statemt_ce0      = 1'b1;
                statemt_ce1      = 1'b1;
                statemt_we0      = 1'b1;
                statemt_we1      = 1'b1;
                statemt_d0       = cap0_q ^ DATA_W'(key_q0);
                statemt_d1       = cap1_q ^ DATA_W'(key_q1);
            end
            WB: begin
                statemt_address0 = col_base | SA_W'(2);
                statemt_address1 = col_base | SA_W'(3);
                statemt_ce0      = 1'b1;
                statemt_ce1      = 1'b1;
                statemt_we0      = 1'b1;
                statemt_we1      = 1'b1;
                statemt_d0       = x2_q;
                statemt_d1       = x3_q;
            end
            default: ;
        endcase
    end

    assign ap_ready = (state_q == CHK) && col_done;
    assign ap_idle  = (state_q == IDLE) && !ap_start;
    assign ap_done  = ap_ready || ap_idle;
    assign ap_err   = (state_q == CHK) && err_q;

endmodule
